// File: rtl/hfosc_pwr_ctrl.sv
// Power sequencer and request arbiter for the iCE40UP HFOSC wrapper; optional idle power-down under HFOSC_PWR_CTRL_IDLE_OFF_EN.
// Latency: cold start grants after PWRUP_CYCLES edges; when warm, ack follows req by one edge.
// Backpressure: none; ack is held low while the oscillator output is disabled, and all requesters are granted together.
module hfosc_pwr_ctrl #(
   parameter int NREQ         = 4,
   parameter int PWRUP_CYCLES = 1200,
   parameter int IDLE_CYCLES  = 4800
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] ack,
   output logic            osc_pu,
   output logic            osc_en,
   output logic            clk_ready,
   output logic            busy
);

   localparam int MAXC = (PWRUP_CYCLES > IDLE_CYCLES) ? PWRUP_CYCLES : IDLE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_CYCLES - 1);
`ifdef HFOSC_PWR_CTRL_IDLE_OFF_EN
   localparam logic [CW-1:0] IDLE_LD  = CW'(IDLE_CYCLES - 1);
`endif

   localparam logic [2:0] ST_OFF   = 3'd0;
   localparam logic [2:0] ST_PWRUP = 3'd1;
   localparam logic [2:0] ST_ON    = 3'd2;
   localparam logic [2:0] ST_IDLE  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   logic [2:0]      state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            any_req;
   logic            grant_nxt;

   assign any_req = |req;

   // Next-state and counter: PWRUP always completes; IDLE returns to ON on any request.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_OFF: begin
            if (any_req) begin
               state_nxt = ST_PWRUP;
               cnt_nxt   = PWRUP_LD;
            end
         end
         ST_PWRUP: begin
            if (cnt == '0) state_nxt = ST_ON;
            else           cnt_nxt   = cnt - CW'(1);
         end
         ST_ON: begin
            if (!any_req) begin
               state_nxt = ST_IDLE;
`ifdef HFOSC_PWR_CTRL_IDLE_OFF_EN
               cnt_nxt   = IDLE_LD;
`endif
            end
         end
         ST_IDLE: begin
            if (any_req) state_nxt = ST_ON;
`ifdef HFOSC_PWR_CTRL_IDLE_OFF_EN
            else if (cnt == '0) state_nxt = ST_DRAIN;
            else                cnt_nxt   = cnt - CW'(1);
`endif
         end
         // DRAIN exists so en falls one cycle ahead of pu.
         ST_DRAIN: state_nxt = ST_OFF;
         default:  state_nxt = ST_OFF;
      endcase
   end

   assign grant_nxt = (state_nxt == ST_ON) || (state_nxt == ST_IDLE);

   // State, counter and registered grants.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_OFF;
         cnt   <= '0;
         ack   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ack   <= req & {NREQ{grant_nxt}};
      end
   end

   // Oscillator controls are decoded straight from the state register.
   always_comb begin
      osc_pu    = (state == ST_PWRUP) || (state == ST_ON) ||
                  (state == ST_IDLE)  || (state == ST_DRAIN);
      osc_en    = (state == ST_ON) || (state == ST_IDLE);
      clk_ready = osc_en;
      busy      = osc_pu;
   end

endmodule

// File: tb/tb_hfosc_pwr_ctrl.sv
// Directed bench for hfosc_pwr_ctrl with PWRUP_CYCLES=4, IDLE_CYCLES=3, NREQ=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Idle power-down expectations follow HFOSC_PWR_CTRL_IDLE_OFF_EN.
module tb_hfosc_pwr_ctrl;

   localparam int NREQ = 4;
   localparam int PWRUP = 4;
   localparam int IDLE  = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] ack;
   logic            osc_pu, osc_en, clk_ready, busy;

   int n_checks = 0;
   int n_fail   = 0;

   hfosc_pwr_ctrl #(
      .NREQ(NREQ), .PWRUP_CYCLES(PWRUP), .IDLE_CYCLES(IDLE)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .ack(ack),
      .osc_pu(osc_pu), .osc_en(osc_en), .clk_ready(clk_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            rst;
      logic [NREQ-1:0] req;
      logic [NREQ-1:0] ack;
      logic            pu;
      logic            en;
      logic            rdy;
      logic            bsy;
   } vec_t;

   vec_t vecs[12];

   // Apply inputs, clock one edge, land 1 unit after it.
   task automatic step(input logic r, input logic [NREQ-1:0] q);
      rst = r;
      req = q;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [NREQ-1:0] e_ack,
                        input logic e_pu, input logic e_en, input logic e_rdy, input logic e_bsy);
      logic [NREQ+3:0] act, exp;
      act = {ack, osc_pu, osc_en, clk_ready, busy};
      exp = {e_ack, e_pu, e_en, e_rdy, e_bsy};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got {ack,pu,en,rdy,busy}=%b, expected %b", name, act, exp);
      end
   endtask

   // From OFF with q held: PWRUP cycles of pu-only, then granted.
   task automatic cold_start(input string name, input logic [NREQ-1:0] q);
      for (int i = 0; i < PWRUP; i++) begin
         step(1'b0, q);
         check(name, '0, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      step(1'b0, q);
      check(name, q, 1'b1, 1'b1, 1'b1, 1'b1);
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      #1;

      //          rst   req      ack      pu    en    rdy   busy
      vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0}; // reset
      vecs[1]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1}; // edge 1: PWRUP
      vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1}; // edge 5: ON
      vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1}; // swap requesters
      vecs[7]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 4'b0110, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1}; // F: IDLE
      vecs[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1}; // IDLE cnt reaches 0

      for (int i = 0; i < 12; i++) begin
         step(vecs[i].rst, vecs[i].req);
         check($sformatf("vec%0d", i), vecs[i].ack, vecs[i].pu, vecs[i].en,
               vecs[i].rdy, vecs[i].bsy);
      end

`ifdef HFOSC_PWR_CTRL_IDLE_OFF_EN
      // F+3: en falls, pu still up; F+4: fully off.
      step(1'b0, 4'b0000); check("drain_en_low", '0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 4'b0000); check("off_after_drain", '0, 1'b0, 1'b0, 1'b0, 1'b0);

      cold_start("restart", 4'b0010);

      // Re-request at IDLE count 1.
      step(1'b0, 4'b0000); check("idle_a0", '0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 4'b0000); check("idle_a1", '0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 4'b1000); check("rereq_cnt1", 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1);

      // Re-request on the exact expiry edge.
      step(1'b0, 4'b0000); check("idle_b0", '0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 4'b0000); check("idle_b1", '0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 4'b0000); check("idle_b2", '0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 4'b0001); check("rereq_expiry", 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);

      // Request arriving in DRAIN: one OFF cycle, then full start-up.
      for (int i = 0; i < IDLE + 1; i++) step(1'b0, 4'b0000);
      check("drain_reached", '0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 4'b0001); check("req_in_drain_off", '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cold_start("drain_restart", 4'b0001);
`else
      // No idle power-down: the oscillator stays up indefinitely.
      for (int i = 0; i < 110; i++) begin
         step(1'b0, 4'b0000);
         check($sformatf("stay_on%0d", i), '0, 1'b1, 1'b1, 1'b1, 1'b1);
      end
      step(1'b0, 4'b1001); check("rereq_idle", 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 4'b0001); check("ack_fall", 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
`endif

      // Reset in ON, then held request restarts start-up.
      step(1'b0, 4'b0001); check("on_before_rst", 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 4'b0001); check("rst_mid_on", '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b0001); check("pwrup_after_rst", '0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 4'b0001); check("pwrup_2", '0, 1'b1, 1'b0, 1'b0, 1'b1);

      // Reset in PWRUP, then a full fresh start-up with the request held.
      step(1'b1, 4'b0001); check("rst_mid_pwrup", '0, 1'b0, 1'b0, 1'b0, 1'b0);
      cold_start("after_rst_pwrup", 4'b0001);

      // Request dropping during PWRUP does not abort; ON then goes idle with no ack.
      step(1'b1, 4'b0000); check("rst_again", '0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'b0100); check("short_req", '0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < PWRUP - 1; i++) step(1'b0, 4'b0000);
      check("pwrup_no_abort", '0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 4'b0000); check("on_without_req", '0, 1'b1, 1'b1, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hfosc_pwr_ctrl.md
# hfosc_pwr_ctrl

Power sequencer and request arbiter for the iCE40UP high-frequency oscillator wrapper. Several fabric clients (camera capture, ML engine, SPI flash loader, ...) request the 48 MHz clock through independent req/ack pairs. The block powers the oscillator up and holds output enable low for the mandatory 100 µs start-up window. It then enables the output, acknowledges requesters, and powers the oscillator down after a configurable idle time once nobody needs it. Runs on the always-on system clock, not on the oscillator output.

## Interface
- NREQ, 4, number of requesters (1..8)
- PWRUP_CYCLES, 1200, clk cycles osc_pu is held high with osc_en low before enabling (100 µs at 12 MHz); ≥1
- IDLE_CYCLES, 4800, clk cycles with no request before power-down; ≥1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester clock request, level, synchronous to clk; held high while clock is needed
- ack  out  NREQ  per-requester grant: oscillator running and request accepted
- osc_pu  out  1  drives oscillator CLKHFPU
- osc_en  out  1  drives oscillator CLKHFEN
- clk_ready  out  1  oscillator output enabled and stable
- busy  out  1  state ≠ OFF

## Operation
- States: OFF, PWRUP, ON, IDLE, DRAIN. Counter width $clog2(max(PWRUP_CYCLES, IDLE_CYCLES)+1).
- Output encoding: OFF pu=0 en=0; PWRUP pu=1 en=0; ON/IDLE pu=1 en=1 clk_ready=1; DRAIN pu=1 en=0 clk_ready=0.
- OFF: |req → PWRUP, cnt ← PWRUP_CYCLES-1.
- PWRUP: cnt decrements each edge; at an edge where cnt==0 → ON, regardless of req. A request dropping during PWRUP does not abort start-up.
- ON: |req==0 → IDLE, cnt ← IDLE_CYCLES-1.
- IDLE: |req → ON (no re-wait). Otherwise cnt decrements; at an edge where cnt==0 → DRAIN.
- DRAIN: unconditional → OFF after one cycle, giving en falling one cycle before pu. Requests present in DRAIN or OFF restart the full PWRUP sequence.
- ack is registered: ack[i] ← req[i] & (next_state ∈ {ON, IDLE}). It never asserts while osc_en is low.
- All requesters are granted simultaneously. This is a shared, non-exclusive resource, so no priority is applied.

## Timing
- Reset values: ack=0, osc_pu=0, osc_en=0, clk_ready=0, busy=0, state=OFF, cnt=0. All take effect on the first rst edge.
- rst mid-operation, in any state: next edge forces OFF, and pu and en drop together.
- Latency, cold start: req high sampled at edge E → pu=1 after E. osc_en, clk_ready and ack after edge E+PWRUP_CYCLES. osc_en is low for exactly PWRUP_CYCLES cycles with pu high.
- Latency, warm (ON/IDLE): ack[i] follows req[i] by 1 cycle, both rising and falling.
- Release: last req low sampled at edge F → IDLE after F. DRAIN after edge F+IDLE_CYCLES. OFF after edge F+IDLE_CYCLES+1.
- Simultaneous events:
  - req rising on the same edge IDLE's cnt hits 0: the request wins, → ON.
  - req rising in DRAIN: goes to OFF, then PWRUP on the following edge.

## Configuration
- HFOSC_PWR_CTRL_IDLE_OFF_EN defined: idle power-down as described above.
- Undefined:
  - IDLE never counts down and never enters DRAIN; once started, the oscillator stays on until rst.
  - IDLE_CYCLES is ignored.
  - ON↔IDLE transitions and ack behaviour are unchanged.

## Test plan
- Cold start, PWRUP_CYCLES=4: req[0]=1 at edge 1 → osc_pu=1 after edge 1, osc_en=clk_ready=ack[0]=1 after edge 5, osc_en=0 for cycles 2–5.
- Multi-requester: in ON, raise req[2], drop req[0] → ack[2]=1 and ack[0]=0 one edge later; state stays ON, pu/en unchanged.
- Idle power-down, IDLE_CYCLES=3, macro defined: all req low at edge F → osc_en=0 after F+3, osc_pu=0 after F+4, busy=0. Macro undefined: pu=en=1 for 100+ cycles.
- Re-request in IDLE at count 1, and on the exact expiry edge → returns to ON, no en drop, ack 1 cycle later.
- Request during DRAIN → OFF for one cycle, then full PWRUP_CYCLES wait before ack.
- rst asserted mid-PWRUP and mid-ON → all outputs 0 after the next edge. A held req restarts PWRUP after rst deasserts.
